// File: rtl/univ_shift_serializer_if.sv
// Word-in / serial-out bundle between a word source, the serializer and a universal shift register.
// Latency: none (signal bundle only). Backpressure: in_ready low while a frame is in flight.
interface univ_shift_serializer_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         dir;
   logic         sdo;
   logic         sdo_shift;
   logic [1:0]   ctrl_out;
   logic         sdo_par;
   logic         busy;
   logic         done;

   modport master (
      output in_valid, in_data, dir,
      input  in_ready, sdo, sdo_shift, ctrl_out, sdo_par, busy, done
   );

   modport slave (
      input  in_valid, in_data, dir,
      output in_ready, sdo, sdo_shift, ctrl_out, sdo_par, busy, done
   );
endinterface

// File: rtl/univ_shift_serializer.sv
// Parallel-to-serial transmitter feeding a universal shift register; SERIALIZER_PARITY_EN appends an even-parity bit.
// Latency: first bit on sdo the cycle after accept, NB*DIV cycles per frame, one word per NB*DIV+1 cycles.
// Backpressure: in_ready is low for the whole frame; inputs are ignored until the frame ends.
module univ_shift_serializer #(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input logic                   clk,
   input logic                   rst,
   univ_shift_serializer_if.slave bus
);
`ifdef SERIALIZER_PARITY_EN
   localparam int NB = N + 1;
`else
   localparam int NB = N;
`endif
   localparam int BW = $clog2(N + 2);
   localparam int DW = (DIV > 1) ? $clog2(DIV + 1) : 1;
   localparam logic [BW-1:0] NB_CNT   = BW'(NB);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  shreg_q;
   logic          dir_q;
   logic [BW-1:0] bcnt_q;
   logic [DW-1:0] div_q;
   logic          accept;
   logic          strobe;
   logic          last_bit;
   logic          par_phase;
   logic          data_bit;

`ifdef SERIALIZER_PARITY_EN
   logic          par_q;
`endif

   assign strobe   = (state_q == SHIFT) && (div_q == DIV_LAST);
   assign last_bit = (bcnt_q == BW'(1));
   assign data_bit = dir_q ? shreg_q[0] : shreg_q[N-1];

`ifdef SERIALIZER_PARITY_EN
   assign par_phase = last_bit;
`else
   assign par_phase = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.sdo       = 1'b0;
      bus.sdo_shift = 1'b0;
      bus.ctrl_out  = 2'b00;
      bus.sdo_par   = 1'b0;
      bus.done      = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bus.busy      = 1'b1;
            bus.sdo_shift = strobe;
`ifdef SERIALIZER_PARITY_EN
            bus.sdo       = par_phase ? par_q : data_bit;
            bus.sdo_par   = par_phase;
`else
            bus.sdo       = data_bit;
`endif
            // Parity strobes still pulse sdo_shift but must not shift the consumer.
            if (strobe && !par_phase) bus.ctrl_out = dir_q ? 2'b10 : 2'b01;
            if (strobe && last_bit) begin
               bus.done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         dir_q   <= 1'b0;
         bcnt_q  <= '0;
         div_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (accept) begin
         shreg_q <= bus.in_data;
         dir_q   <= bus.dir;
         bcnt_q  <= NB_CNT;
         div_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
         par_q   <= ^bus.in_data;
`endif
      end else if (state_q == SHIFT) begin
         if (strobe) begin
            shreg_q <= dir_q ? {1'b0, shreg_q[N-1:1]} : {shreg_q[N-2:0], 1'b0};
            bcnt_q  <= bcnt_q - BW'(1);
            div_q   <= '0;
         end else begin
            div_q   <= div_q + DW'(1);
         end
      end
   end
endmodule

// File: tb/tb_univ_shift_serializer.sv
// Bench for univ_shift_serializer: per-cycle frame model plus a downstream universal shift register model.
// Honours SERIALIZER_PARITY_EN when defined for the build.
module tb_univ_shift_serializer;
   localparam int N   = 8;
   localparam int DIV = 4;
`ifdef SERIALIZER_PARITY_EN
   localparam int NB = N + 1;
`else
   localparam int NB = N;
`endif
   localparam int F = NB * DIV;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   univ_shift_serializer_if #(.N(N)) bus();

   univ_shift_serializer #(.N(N), .DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int last_wait;
   logic [N-1:0] cons;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Sends one word and checks every cycle of its frame against the bit schedule.
   task automatic run_frame(input logic [N-1:0] word, input logic d, input bit junk, input bit keep_valid);
      int   k;
      bit   got;
      logic exp_sdo, exp_stb, exp_par, exp_done;
      logic [1:0] exp_ctrl;
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      bus.dir      = d;
      got = 0;
      last_wait = 0;
      for (int w = 0; w < 200 && !got; w++) begin
         @(negedge clk);
         last_wait++;
         if (bus.in_ready === 1'b1) got = 1;
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL accept_timeout word=%h: in_ready=%b after %0d cycles, required 1", word, bus.in_ready, last_wait);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!keep_valid) bus.in_valid = 1'b0;
      cons = '0;
      for (int c = 1; c <= F; c++) begin
         @(negedge clk);
         k        = (c - 1) / DIV;
         exp_sdo  = (k < N) ? (d ? word[k] : word[N-1-k]) : ^word;
         exp_stb  = ((c % DIV) == 0);
         exp_ctrl = (exp_stb && k < N) ? (d ? 2'b10 : 2'b01) : 2'b00;
         exp_done = (c == F);
         exp_par  = (k >= N);
         n_cmp++;
         if (bus.sdo !== exp_sdo) begin
            n_err++;
            $display("FAIL sdo word=%h cyc=%0d: got %b, required %b", word, c, bus.sdo, exp_sdo);
         end
         n_cmp++;
         if (bus.sdo_shift !== exp_stb) begin
            n_err++;
            $display("FAIL sdo_shift word=%h cyc=%0d: got %b, required %b", word, c, bus.sdo_shift, exp_stb);
         end
         n_cmp++;
         if (bus.ctrl_out !== exp_ctrl) begin
            n_err++;
            $display("FAIL ctrl_out word=%h cyc=%0d: got %b, required %b", word, c, bus.ctrl_out, exp_ctrl);
         end
         n_cmp++;
         if (bus.done !== exp_done) begin
            n_err++;
            $display("FAIL done word=%h cyc=%0d: got %b, required %b", word, c, bus.done, exp_done);
         end
         n_cmp++;
         if (bus.sdo_par !== exp_par) begin
            n_err++;
            $display("FAIL sdo_par word=%h cyc=%0d: got %b, required %b", word, c, bus.sdo_par, exp_par);
         end
         n_cmp++;
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ready word=%h cyc=%0d: got busy=%b in_ready=%b, required 1/0", word, c, bus.busy, bus.in_ready);
         end
         if (bus.ctrl_out == 2'b01)      cons = {cons[N-2:0], bus.sdo};
         else if (bus.ctrl_out == 2'b10) cons = {bus.sdo, cons[N-1:1]};
         if (junk) begin
            bus.dir      = ~bus.dir;
            bus.in_data  = N'($urandom);
            bus.in_valid = 1'b1;
         end
      end
      if (!keep_valid) bus.in_valid = 1'b0;
      n_cmp++;
      if (cons !== word) begin
         n_err++;
         $display("FAIL consumer word: got %h, required %h", cons, word);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sdo !== 1'b0 ||
          bus.ctrl_out !== 2'b00 || bus.done !== 1'b0 || bus.sdo_shift !== 1'b0 || bus.sdo_par !== 1'b0) begin
         n_err++;
         $display("FAIL idle_%s: got rdy=%b busy=%b sdo=%b ctrl=%b done=%b stb=%b par=%b, required 1 0 0 00 0 0 0",
                  tag, bus.in_ready, bus.busy, bus.sdo, bus.ctrl_out, bus.done, bus.sdo_shift, bus.sdo_par);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      bus.dir      = 1'b0;
      check_idle("reset1");
      check_idle("reset2");
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check_idle("after_reset");
   endtask

   task automatic test_msb_first();
      run_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      check_idle("msb_end");
   endtask

   task automatic test_lsb_first();
      run_frame(8'h0F, 1'b1, 1'b1, 1'b0);
      check_idle("lsb_end");
   endtask

   task automatic test_back_to_back();
      run_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      run_frame(8'hC3, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (last_wait != 1) begin
         n_err++;
         $display("FAIL b2b_gap: second accept %0d cycles after done, required 1", last_wait);
      end
      check_idle("b2b_end");
   endtask

   task automatic test_reset_mid_frame();
      bit got = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.dir      = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) got = 1;
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL midrst_accept: in_ready=%b, required 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 3 * DIV; c++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.sdo !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_frame cyc=%0d: got sdo=%b done=%b busy=%b, required 1 0 1", c, bus.sdo, bus.done, bus.busy);
         end
      end
      rst = 1'b1;
      check_idle("midrst");
      rst = 1'b0;
      check_idle("midrst_release");
      run_frame(8'h81, 1'b0, 1'b0, 1'b0);
      check_idle("midrst_next_end");
   endtask

   task automatic test_random();
      logic [N-1:0] w;
      logic         d;
      int           gap;
      for (int i = 0; i < 12; i++) begin
         w   = N'($urandom);
         d   = 1'($urandom_range(0, 1));
         gap = $urandom_range(0, 3);
         run_frame(w, d, 1'($urandom_range(0, 1)), 1'b0);
         for (int g = 0; g < gap; g++) check_idle("rand_gap");
      end
   endtask

`ifdef SERIALIZER_PARITY_EN
   task automatic test_parity();
      run_frame(8'h07, 1'b0, 1'b0, 1'b0);
      check_idle("parity_end");
   endtask
`endif

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.dir      = 1'b0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef SERIALIZER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/univ_shift_serializer.md
Name: univ_shift_serializer

Overview:
- Parallel-to-serial transmitter that drives the serial-input end of the team's universal shift register.
- Accepts an N-bit word over a valid/ready handshake and shifts it out one bit per DIV clocks, MSB-first or LSB-first.
- Emits a per-bit shift strobe and a matching 2-bit shift-control code, so a downstream universal shift register reassembles the word directly.

Parameters:
- N, 8, word width in bits (N >= 2).
- DIV, 4, clocks per bit period (DIV >= 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  word available on in_data.
- in_ready  output  1  serializer can accept a word.
- in_data  input  N  word to transmit.
- dir  input  1  0 = MSB-first (consumer ctrl 2'b01, shift left), 1 = LSB-first (consumer ctrl 2'b10, shift right); sampled at accept.
- sdo  output  1  serial data out.
- sdo_shift  output  1  one-cycle strobe on the last cycle of each bit period.
- ctrl_out  output  2  consumer shift code: 2'b01 or 2'b10 while sdo_shift is high, else 2'b00.
- sdo_par  output  1  high during the parity bit period; tied 0 without the macro.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on the final strobe of a frame.

Behaviour:
- Reset, sampled on clk only, overrides everything:
  - state IDLE, in_ready=1, sdo=0, sdo_shift=0, ctrl_out=2'b00, sdo_par=0, busy=0, done=0.
  - Shift register, bit counter and divider counter cleared.
- States are IDLE and SHIFT.
- IDLE:
  - in_ready=1, busy=0, sdo=0.
  - Accept happens on the edge where in_valid && in_ready. That edge latches in_data into the shift register, latches dir, sets bit counter = NB (N, or N+1 with parity), sets divider = 0, and moves to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - sdo presents the current bit from the cycle after accept: in_data[N-1] first when dir=0, in_data[0] first when dir=1.
  - Each bit is held for exactly DIV cycles.
  - The divider counts 0..DIV-1. On count DIV-1: sdo_shift=1 and ctrl_out = dir ? 2'b10 : 2'b01. On the next edge the register shifts (left for dir=0, right for dir=1), the bit counter decrements, and the divider wraps to 0.
  - With DIV=1, sdo_shift is high every SHIFT cycle.
- Frame end:
  - When the strobe coincides with bit counter == 1, done=1 for that cycle.
  - Next state is IDLE. in_ready rises the following cycle, and sdo returns to 0.
- Throughput: one word per NB*DIV + 1 cycles; frame length is NB*DIV cycles in SHIFT.
- Changes to in_data, dir or in_valid during SHIFT are ignored; no word is accepted mid-frame.
- Reset mid-frame aborts immediately: the partial frame is discarded with no done pulse, and outputs take their reset values on the next edge.
- Counter widths: bit counter $clog2(N+2) bits; divider $clog2(DIV+1) bits, minimum 1 bit.
- All outputs are registered (no combinational path from in_valid to any output); ctrl_out and sdo_shift are decoded from registered state.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - NB = N+1. After the N data bits, one extra bit is sent: even parity, the XOR of the latched word.
  - During that bit period sdo_par=1. Its strobe asserts sdo_shift, but ctrl_out stays 2'b00, so the consumer does not shift parity into its data.
  - done coincides with the parity strobe.
- Undefined:
  - NB = N, sdo_par is constant 0, and no parity logic is synthesized.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=1, busy=0, sdo=0, ctrl_out=00, done=0; no accept occurs during reset.
- MSB-first, N=8, DIV=4: in_data=8'hA5, dir=0 -> sdo sequence 1,0,1,0,0,1,0,1, each bit 4 cycles; 8 strobes with ctrl_out=01; done at cycle 32 after accept; attached univ shift register ends holding 8'hA5.
- LSB-first: in_data=8'h0F, dir=1 -> sdo 1,1,1,1,0,0,0,0; ctrl_out=10 on strobes; consumer holds 8'h0F; dir toggled mid-frame has no effect.
- Back-to-back: in_valid held high with 8'h3C, then 8'hC3 -> in_ready low for 32 cycles; second word accepted exactly 1 cycle after first done; both words received intact.
- Reset mid-frame: rst pulsed after 3 strobes of 8'hFF -> next cycle IDLE with no done pulse; a following word 8'h81 is transmitted fully and correctly.
- SERIALIZER_PARITY_EN: in_data=8'h07, dir=0 -> 9th bit sdo=1 with sdo_par=1; ctrl_out=00 on the 9th strobe; done at cycle 36; consumer holds 8'h07.
